mem_fifo_ctrl: RTL and testbench
================================

MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, storage address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_data/in_valid/in_ready  in/in/out  WIDTH/1/1  producer stream; transfer when in_valid && in_ready.
REQ-006 SHALL have ports out_data/out_valid/out_ready  out/out/in  WIDTH/1/1  consumer stream; pop when out_valid && out_ready.
REQ-007 SHALL have ports W_data/W_addr/W_en  out/out/out  WIDTH/ADDR_WIDTH/1  write side of the storage array.
REQ-008 SHALL have ports R_addr/R_en  out/out  ADDR_WIDTH/1  read side of the storage array.
REQ-009 SHALL have port R_data  input  WIDTH  registered read data, valid the cycle after R_en is sampled.
REQ-010 SHALL have port count  output  ADDR_WIDTH+1  total entries held (storage + in flight + output register).

Function
REQ-011 SHALL keep wr_ptr and rd_ptr, ADDR_WIDTH+1 bits each, wrapping modulo 2*DEPTH; mem_cnt = wr_ptr - rd_ptr (0..DEPTH).
REQ-012 SHALL issue a read (rd_go) when mem_cnt != 0 && !rd_pend && (!out_valid || out_ready).
REQ-013 SHALL drive R_en = rd_go, R_addr = rd_ptr[ADDR_WIDTH-1:0]; rd_ptr increments and rd_pend sets at the edge after rd_go.
REQ-014 SHALL drive in_ready = (mem_cnt < DEPTH) && !rd_go; reads have priority because storage ignores R_en while W_en is high.
REQ-015 SHALL drive W_en = in_valid && in_ready, W_addr = wr_ptr[ADDR_WIDTH-1:0], W_data = in_data; wr_ptr increments on W_en.
REQ-016 SHALL never assert W_en and R_en in the same cycle.
REQ-017 SHALL, when rd_pend is 1, capture R_data into out_data, set out_valid and clear rd_pend at the next edge.
REQ-018 SHALL clear out_valid at the edge of a pop unless a capture occurs at that same edge.
REQ-019 SHALL hold out_data stable while out_valid && !out_ready.
REQ-020 SHALL never have rd_pend and out_valid both 1.
REQ-021 SHALL drive count = mem_cnt + rd_pend + out_valid; maximum DEPTH+1.
REQ-022 SHALL have minimum latency 3 cycles from in_data accept to out_valid on an empty FIFO, and sustained throughput 1 word per 2 cycles.
REQ-023 SHALL deassert in_ready when full (mem_cnt == DEPTH); an in_valid that is not accepted SHALL cause no state change.
REQ-024 SHALL ignore R_data whenever rd_pend is 0, including high-impedance values.
REQ-025 SHALL handle pointer wrap from 2*DEPTH-1 to 0 with no loss of full/empty distinction.

Reset
REQ-026 SHALL, on reset_n low, immediately clear wr_ptr, rd_ptr, rd_pend, out_valid and out_data to 0; count reads 0.
REQ-027 SHALL, on reset mid-operation, discard all held and in-flight words; storage contents are not cleared and are not re-read.
REQ-028 SHALL hold in_ready, W_en and R_en at 0 while reset_n is low.

Structure
REQ-029 SHALL take WIDTH and ADDR_WIDTH defaults from the shared memory-subsystem package, alongside the storage block's defaults.
REQ-030 SHALL be a single module with no sub-modules; the storage array is instantiated beside it by the integrator.

Verification
REQ-031 SHALL cover: push 0xA5A5A5A5 into an empty FIFO, out_ready=1 -> W_en at cycle 0, R_en at cycle 1, out_valid at cycle 3 with 0xA5A5A5A5, count 1 then 0.
REQ-032 SHALL cover: push 5 words with out_ready=0 -> 4 reach storage, 1 reaches the output register, in_ready=0 at count 5, no word lost.
REQ-033 SHALL cover: in_valid=1 and out_ready=1 continuously for 20 cycles -> in-order data, never W_en&&R_en, steady 1 word per 2 cycles.
REQ-034 SHALL cover: 12 push/pop pairs -> pointers wrap past 7, order preserved, count returns to 0.
REQ-035 SHALL cover: reset_n pulsed low with count 3 -> out_valid, count and R_en are 0 immediately; the next push reads back correctly.
REQ-036 SHALL cover: out_ready toggling 1,0,0,1 during streaming -> out_data stable while stalled, no duplicate or dropped words.

Source files
------------

// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared memory-subsystem package.
// Holds the default data width and address width used by the FIFO controller
// and by the storage array that sits beside it, so both always agree.
// Also provides a helper that turns an address width into an entry count.
package mem_fifo_ctrl_pkg;

    // Default word width shared by the controller and the storage block.
    localparam int MEM_WIDTH      = 32;
    // Default storage address width shared by the controller and the storage block.
    localparam int MEM_ADDR_WIDTH = 2;

    // Number of storage entries addressed by an address of the given width.
    function automatic int mem_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/mem_fifo_ctrl_if.sv
// Storage-array bus between the FIFO controller and the registered-read storage.
// Ports (signals):
//   W_data/W_addr/W_en : write side, driven by the controller
//   R_addr/R_en        : read request, driven by the controller
//   R_data             : registered read data, valid the cycle after R_en is sampled
// Modports: master = controller side, slave = storage side.
interface mem_fifo_ctrl_if
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);
    logic [WIDTH-1:0]      W_data;
    logic [ADDR_WIDTH-1:0] W_addr;
    logic                  W_en;
    logic [ADDR_WIDTH-1:0] R_addr;
    logic                  R_en;
    logic [WIDTH-1:0]      R_data;

    modport master (
        output W_data, W_addr, W_en, R_addr, R_en,
        input  R_data
    );

    modport slave (
        input  W_data, W_addr, W_en, R_addr, R_en,
        output R_data
    );
endinterface

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of an external storage array with registered reads.
// Words entering on the producer stream are written into storage; words are
// read back one at a time into an output register that feeds the consumer.
// Ports:
//   clock, reset_n                 : single clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      : producer stream (transfer on valid && ready)
//   out_data/out_valid/out_ready   : consumer stream (pop on valid && ready)
//   mem                            : storage bus (write port, read request, R_data)
//   count                          : words held (storage + read in flight + output register)
module mem_fifo_ctrl
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    mem_fifo_ctrl_if.master       mem,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                DEPTH   = mem_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

    // Pointers carry one extra bit so full (difference DEPTH) and empty
    // (difference 0) stay distinct across wrap.
    logic [ADDR_WIDTH:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q,  rd_ptr_d;
    logic                rd_pend_q, rd_pend_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;

    logic [ADDR_WIDTH:0] mem_cnt;
    logic                rd_go;
    logic                wr_go;
    logic                pop;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        mem_cnt = wr_ptr_q - rd_ptr_q;

        // A read is launched only when the output register will be free by the
        // time the data returns; reset_n gating keeps the strobes quiet in reset.
        rd_go    = reset_n && (mem_cnt != '0) && !rd_pend_q && (!out_valid_q || out_ready);
        // The storage drops R_en while W_en is high, so reads win the slot.
        in_ready = reset_n && (mem_cnt != DEPTH_P) && !rd_go;
        wr_go    = in_valid && in_ready;
        pop      = out_valid_q && out_ready;

        if (wr_go) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (rd_go) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // rd_go already excludes a pending read, so the pending flag is just
        // the previous cycle's launch.
        rd_pend_d = rd_go;

        // R_data is only looked at while a read is pending; at other times it
        // may be stale or floating. A capture never coincides with a pop
        // because rd_pend and out_valid are mutually exclusive.
        if (rd_pend_q) begin
            out_data_d  = mem.R_data;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        count = mem_cnt + (ADDR_WIDTH+1)'(rd_pend_q) + (ADDR_WIDTH+1)'(out_valid_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            // NOTE: the output data register is cleared too so the consumer never sees X after reset; the storage array itself is never reset.
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_pend_q   <= rd_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign mem.W_en   = wr_go;
    assign mem.W_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign mem.W_data = in_data;
    assign mem.R_en   = rd_go;
    assign mem.R_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Testbench for mem_fifo_ctrl.
// A registered-read storage model sits on the storage bus and floats R_data
// whenever no read result is being presented. The reference model is a plain
// queue of accepted words: every pop must return its head and count must equal
// its size at every cycle.
module tb_mem_fifo_ctrl;
    import mem_fifo_ctrl_pkg::*;

    localparam int WIDTH = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [AW:0]      count;

    mem_fifo_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

    mem_fifo_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mem       (bus),
        .count     (count)
    );

    always #5 clock = ~clock;

    // Storage model: write has priority, read data registered, floating otherwise.
    logic [WIDTH-1:0] store [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic             rd_vld = 1'b0;

    always @(posedge clock) begin
        rd_vld <= 1'b0;
        if (bus.W_en) begin
            store[bus.W_addr] <= bus.W_data;
        end else if (bus.R_en) begin
            rd_q   <= store[bus.R_addr];
            rd_vld <= 1'b1;
        end
    end

    assign bus.R_data = rd_vld ? rd_q : 'z;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    // Values observed in the most recent cycle.
    logic             s_w_en, s_r_en, s_out_valid, s_in_ready, s_push, s_pop;
    logic [WIDTH-1:0] s_out_data;
    int               s_count;

    // One clock cycle: observe at the falling edge, compare against the
    // queue model, update it, then return just after the rising edge.
    task automatic tick();
        logic [WIDTH-1:0] exp_word;
        @(negedge clock);
        s_w_en      = bus.W_en;
        s_r_en      = bus.R_en;
        s_out_valid = out_valid;
        s_in_ready  = in_ready;
        s_out_data  = out_data;
        s_count     = int'(count);
        s_push      = in_valid && in_ready;
        s_pop       = out_valid && out_ready;

        checks++;
        if (bus.W_en && bus.R_en) begin
            errors++;
            $display("FAIL wr_rd_overlap: W_en=%b R_en=%b required not both 1", bus.W_en, bus.R_en);
        end
        checks++;
        if (s_count !== exp_q.size()) begin
            errors++;
            $display("FAIL count: got %0d expected %0d", s_count, exp_q.size());
        end
        checks++;
        if (bus.W_en !== s_push) begin
            errors++;
            $display("FAIL w_en: got %b expected %b", bus.W_en, s_push);
        end
        if (exp_q.size() == DEPTH + 1) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_full: got %b expected 0", in_ready);
            end
        end
        if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h expected valid=1 data=%h",
                         out_valid, out_data, prev_data);
            end
        end
        if (s_pop) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_pop: data=%h with empty model", out_data);
            end else begin
                exp_word = exp_q.pop_front();
                if (out_data !== exp_word) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h", out_data, exp_word);
                end
            end
        end
        if (s_push) exp_q.push_back(in_data);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            tick();
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words left expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        #12;
        checks++;
        if (in_ready !== 1'b0 || bus.W_en !== 1'b0 || bus.R_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: in_ready=%b W_en=%b R_en=%b expected 0 0 0",
                     in_ready, bus.W_en, bus.R_en);
        end
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b count=%0d out_data=%h expected 0 0 0",
                     out_valid, count, out_data);
        end
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        exp_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic test_single();
        in_data   = 32'hA5A5_A5A5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if (s_w_en !== 1'b1) begin
            errors++;
            $display("FAIL single_c0_w_en: got %b expected 1", s_w_en);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (s_r_en !== 1'b1 || s_count != 1) begin
            errors++;
            $display("FAIL single_c1: R_en=%b count=%0d expected 1 1", s_r_en, s_count);
        end
        tick();
        checks++;
        if (s_out_valid !== 1'b0 || s_count != 1) begin
            errors++;
            $display("FAIL single_c2: out_valid=%b count=%0d expected 0 1", s_out_valid, s_count);
        end
        tick();
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL single_c3: out_valid=%b data=%h expected 1 a5a5a5a5", s_out_valid, s_out_data);
        end
        tick();
        checks++;
        if (s_count != 0 || s_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_c4: count=%0d out_valid=%b expected 0 0", s_count, s_out_valid);
        end
    endtask

    task automatic test_fill();
        int pushed;
        int budget;
        pushed    = 0;
        budget    = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom;
        while (pushed < 5 && budget < 40) begin
            tick();
            budget++;
            if (s_push) begin
                pushed++;
                in_data = $urandom;
            end
        end
        checks++;
        if (pushed != 5) begin
            errors++;
            $display("FAIL fill_timeout: pushed %0d expected 5", pushed);
        end
        // Keep offering a sixth word: it must be refused.
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (s_count != 5 || s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_w_en !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d in_ready=%b out_valid=%b W_en=%b expected 5 0 1 0",
                     s_count, s_in_ready, s_out_valid, s_w_en);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int writes;
        int pops;
        writes    = 0;
        pops      = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = $urandom;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_push) begin
                writes++;
                in_data = $urandom;
            end
            if (s_pop) pops++;
        end
        checks++;
        if (writes != 10 || pops != 9) begin
            errors++;
            $display("FAIL stream_rate: writes=%0d pops=%0d expected 10 9", writes, pops);
        end
        drain();
    endtask

    task automatic test_wrap();
        int budget;
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            budget   = 0;
            do begin
                tick();
                budget++;
            end while (!s_push && budget < 10);
            in_valid = 1'b0;
            budget   = 0;
            while (exp_q.size() != 0 && budget < 10) begin
                tick();
                budget++;
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL wrap_pair_%0d: %0d words outstanding expected 0", n, exp_q.size());
            end
        end
        tick();
        checks++;
        if (s_count != 0) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 0", s_count);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        int pushed;
        pushed    = 0;
        budget    = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom;
        while (pushed < 3 && budget < 20) begin
            tick();
            budget++;
            if (s_push) begin
                pushed++;
                in_data = $urandom;
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (s_count != 3) begin
            errors++;
            $display("FAIL mid_pre_count: got %0d expected 3", s_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || bus.R_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b count=%0d R_en=%b expected 0 0 0",
                     out_valid, count, bus.R_en);
        end
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        in_data   = 32'h1234_5678;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        pushed    = 0;
        budget    = 0;
        while (budget < 12 && !(pushed == 1 && exp_q.size() == 0)) begin
            tick();
            budget++;
            if (s_push) begin
                pushed++;
                in_valid = 1'b0;
            end
        end
        checks++;
        if (pushed != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_readback: pushed=%0d left=%0d expected 1 0", pushed, exp_q.size());
        end
    endtask

    task automatic test_stall();
        logic pattern [4];
        pattern[0] = 1'b1;
        pattern[1] = 1'b0;
        pattern[2] = 1'b0;
        pattern[3] = 1'b1;
        in_valid = 1'b1;
        in_data  = $urandom;
        for (int i = 0; i < 40; i++) begin
            out_ready = pattern[i % 4];
            tick();
            if (s_push) in_data = $urandom;
        end
        drain();
    endtask

    task automatic test_random();
        in_data = $urandom;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (s_push) in_data = $urandom;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
